// File: rtl/grant_finish_unit.sv
// grant_finish_unit: forwards network grants to the client and queues finish acks on last beats
module grant_finish_unit #(
  parameter int BEATS     = 8,
  parameter int FIN_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        net_gnt_valid,
  output logic        net_gnt_ready,
  input  logic [1:0]  net_gnt_header_src,
  input  logic [2:0]  net_gnt_addr_beat,
  input  logic        net_gnt_client_xact_id,
  input  logic [1:0]  net_gnt_manager_xact_id,
  input  logic        net_gnt_is_builtin_type,
  input  logic [3:0]  net_gnt_g_type,
  input  logic [63:0] net_gnt_data,
  output logic        cli_gnt_valid,
  input  logic        cli_gnt_ready,
  output logic [2:0]  cli_gnt_addr_beat,
  output logic        cli_gnt_client_xact_id,
  output logic [1:0]  cli_gnt_manager_xact_id,
  output logic        cli_gnt_is_builtin_type,
  output logic [3:0]  cli_gnt_g_type,
  output logic [63:0] cli_gnt_data,
  output logic        cli_gnt_manager_id,
  output logic        net_fin_valid,
  input  logic        net_fin_ready,
  output logic [1:0]  net_fin_header_src,
  output logic [1:0]  net_fin_header_dst,
  output logic [1:0]  net_fin_manager_xact_id
);
  localparam int BW = $clog2(BEATS);
  localparam int PW = FIN_DEPTH > 1 ? $clog2(FIN_DEPTH) : 1;
  localparam int CW = $clog2(FIN_DEPTH + 1);
  logic [BW-1:0] beat;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] cnt;
  logic [1:0]    dst_q [FIN_DEPTH];
  logic [1:0]    id_q  [FIN_DEPTH];
  logic needs_ack, multibeat, last_beat, enq, fin_full, stall, push, pop;
  assign needs_ack = !(net_gnt_is_builtin_type && net_gnt_g_type == 4'h0);
  assign multibeat = (net_gnt_is_builtin_type && net_gnt_g_type == 4'h5) ||
                     (!net_gnt_is_builtin_type && net_gnt_g_type <= 4'h1);
  assign last_beat = !multibeat || beat == BW'(BEATS - 1);
  assign enq       = needs_ack && last_beat;
  assign fin_full  = cnt == CW'(FIN_DEPTH);
  assign stall     = enq && fin_full;
  assign cli_gnt_valid = net_gnt_valid && !stall;
  assign net_gnt_ready = cli_gnt_ready && !stall;
  assign push = net_gnt_valid && net_gnt_ready && enq;
  assign pop  = net_fin_valid && net_fin_ready;
  assign cli_gnt_addr_beat       = net_gnt_addr_beat;
  assign cli_gnt_client_xact_id  = net_gnt_client_xact_id;
  assign cli_gnt_manager_xact_id = net_gnt_manager_xact_id;
  assign cli_gnt_is_builtin_type = net_gnt_is_builtin_type;
  assign cli_gnt_g_type          = net_gnt_g_type;
  assign cli_gnt_data            = net_gnt_data;
  assign cli_gnt_manager_id      = net_gnt_header_src[0];
  assign net_fin_valid           = cnt != '0;
  assign net_fin_header_src      = 2'h0;
  assign net_fin_header_dst      = dst_q[rd];
  assign net_fin_manager_xact_id = id_q[rd];
  // count accepted multibeat beats; power-of-two BEATS wraps naturally
  always_ff @(posedge clk or negedge reset)
    if (!reset) beat <= '0;
    else if (net_gnt_valid && net_gnt_ready && multibeat) beat <= beat + 1'b1;
  // finish FIFO: occupancy is registered so a same-cycle pop never frees space for a push
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIN_DEPTH; i++) begin
        dst_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      if (push) begin
        dst_q[wr] <= net_gnt_header_src;
        id_q[wr]  <= net_gnt_manager_xact_id;
        wr        <= wr == PW'(FIN_DEPTH - 1) ? '0 : wr + 1'b1;
      end
      if (pop) rd <= rd == PW'(FIN_DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_grant_finish_unit.sv
// tb_grant_finish_unit: randomized and directed checks against a queue-based reference model
module tb_grant_finish_unit;
  localparam int BEATS = 8;
  localparam int FIN_DEPTH = 2;
  logic clk = 0, reset;
  logic gv, cr, fr, cid, bi;
  logic [1:0] src, mid;
  logic [2:0] ab;
  logic [3:0] gt;
  logic [63:0] data;
  logic net_gnt_ready, cli_gnt_valid, cli_gnt_client_xact_id, cli_gnt_is_builtin_type, cli_gnt_manager_id;
  logic [2:0] cli_gnt_addr_beat;
  logic [1:0] cli_gnt_manager_xact_id;
  logic [3:0] cli_gnt_g_type;
  logic [63:0] cli_gnt_data;
  logic net_fin_valid;
  logic [1:0] net_fin_header_src, net_fin_header_dst, net_fin_manager_xact_id;
  int n_chk = 0, n_fail = 0;
  logic [3:0] fq [$];
  int mbeat = 0;

  always #5 clk = ~clk;

  grant_finish_unit #(.BEATS(BEATS), .FIN_DEPTH(FIN_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .net_gnt_valid(gv), .net_gnt_ready(net_gnt_ready), .net_gnt_header_src(src),
    .net_gnt_addr_beat(ab), .net_gnt_client_xact_id(cid), .net_gnt_manager_xact_id(mid),
    .net_gnt_is_builtin_type(bi), .net_gnt_g_type(gt), .net_gnt_data(data),
    .cli_gnt_valid(cli_gnt_valid), .cli_gnt_ready(cr), .cli_gnt_addr_beat(cli_gnt_addr_beat),
    .cli_gnt_client_xact_id(cli_gnt_client_xact_id), .cli_gnt_manager_xact_id(cli_gnt_manager_xact_id),
    .cli_gnt_is_builtin_type(cli_gnt_is_builtin_type), .cli_gnt_g_type(cli_gnt_g_type),
    .cli_gnt_data(cli_gnt_data), .cli_gnt_manager_id(cli_gnt_manager_id),
    .net_fin_valid(net_fin_valid), .net_fin_ready(fr), .net_fin_header_src(net_fin_header_src),
    .net_fin_header_dst(net_fin_header_dst), .net_fin_manager_xact_id(net_fin_manager_xact_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: inputs already driven after a negedge; check, then advance the model at posedge
  task automatic step(output bit acc);
    bit multi, ack, last, enq, blk, popf;
    #1;
    multi = (bi && gt == 5) || (!bi && gt <= 1);
    ack   = !(bi && gt == 0);
    last  = !multi || mbeat == BEATS - 1;
    enq   = ack && last;
    blk   = enq && fq.size() == FIN_DEPTH;
    check("cli_valid", 64'(cli_gnt_valid), 64'(gv && !blk));
    check("gnt_ready", 64'(net_gnt_ready), 64'(cr && !blk));
    check("cli_data", cli_gnt_data, data);
    check("cli_fields", 64'({cli_gnt_addr_beat, cli_gnt_client_xact_id, cli_gnt_manager_xact_id,
                              cli_gnt_is_builtin_type, cli_gnt_g_type, cli_gnt_manager_id}),
                        64'({ab, cid, mid, bi, gt, src[0]}));
    check("fin_valid", 64'(net_fin_valid), 64'(fq.size() != 0));
    if (fq.size() != 0)
      check("fin_bits", 64'({net_fin_header_src, net_fin_header_dst, net_fin_manager_xact_id}), 64'({2'b00, fq[0]}));
    acc  = gv && cr && !blk;
    popf = fq.size() != 0 && fr;
    @(posedge clk);
    if (popf) void'(fq.pop_front());
    if (acc && enq) fq.push_back({src, mid});
    if (acc && multi) mbeat = (mbeat + 1) % BEATS;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit b, input logic [3:0] g, input logic [1:0] s,
                       input logic [1:0] m, input bit c, input bit f, output bit acc);
    gv = v; bi = b; gt = g; src = s; mid = m; cr = c; fr = f;
    ab = 3'($urandom); cid = 1'($urandom); data = {$urandom, $urandom};
    step(acc);
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #1;
    check("rst_fin_valid", 64'(net_fin_valid), 64'd0);
    check("rst_fin_bits", 64'({net_fin_header_src, net_fin_header_dst, net_fin_manager_xact_id}), 64'd0);
    fq.delete();
    mbeat = 0;
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    bit acc;
    int hs, t;
    reset = 0; gv = 0; cr = 0; fr = 0; cid = 0; bi = 0; src = 0; mid = 0; ab = 0; gt = 0; data = 0;
    @(negedge clk);
    #1;
    check("rst_fin_valid", 64'(net_fin_valid), 64'd0);
    check("rst_fin_bits", 64'({net_fin_header_src, net_fin_header_dst, net_fin_manager_xact_id}), 64'd0);
    check("rst_cli_valid", 64'(cli_gnt_valid), 64'd0);
    @(negedge clk);
    reset = 1;
    // single-beat built-in putAck
    drive(1, 1, 4'h3, 2'd1, 2'd2, 1, 0, acc);
    check("putack_acc", 64'(acc), 64'd1);
    drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // voluntary ack: no finish afterwards
    drive(1, 1, 4'h0, 2'd2, 2'd3, 1, 1, acc);
    for (int i = 0; i < 10; i++) drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // 8-beat getDataBlock with random client stalls
    hs = 0; t = 0;
    while (hs < BEATS && t < 200) begin
      drive(1, 1, 4'h5, 2'd3, 2'd1, 1'($urandom), 0, acc);
      ab = 0;
      hs += int'(acc); t++;
    end
    check("burst_beats", 64'(hs), 64'(BEATS));
    for (int i = 0; i < 3; i++) drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // queue full: third acquire stalls while a non-final data beat passes
    for (int i = 0; i < 3; i++) drive(1, 0, 4'h2, 2'd1, 2'(i), 1, 0, acc);
    check("third_stalled", 64'(acc), 64'd0);
    drive(1, 1, 4'h5, 2'd2, 2'd3, 1, 0, acc);
    check("data_beat_passes", 64'(acc), 64'd1);
    drive(1, 0, 4'h2, 2'd1, 2'd2, 1, 1, acc);
    check("still_stalled", 64'(acc), 64'd0);
    t = 0;
    do begin drive(1, 0, 4'h2, 2'd1, 2'd2, 1, 1, acc); t++; end while (!acc && t < 20);
    check("third_accepted", 64'(acc), 64'd1);
    for (int i = 0; i < 4; i++) drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // finish the open burst so the next test starts at beat 0
    while (mbeat != 0) drive(1, 1, 4'h5, 2'd2, 2'd3, 1, 1, acc);
    for (int i = 0; i < 3; i++) drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // reset mid-burst with a finish queued
    drive(1, 1, 4'h3, 2'd1, 2'd1, 1, 0, acc);
    for (int i = 0; i < 3; i++) drive(1, 1, 4'h5, 2'd3, 2'd2, 1, 0, acc);
    do_reset();
    for (int i = 0; i < BEATS; i++) drive(1, 1, 4'h5, 2'd1, 2'd3, 1, 0, acc);
    check("post_rst_fin", 64'(fq.size()), 64'd1);
    for (int i = 0; i < 3; i++) drive(0, 0, 4'h0, 0, 0, 1, 1, acc);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] k;
      k = 5'($urandom_range(0, 7));
      case (k)
        0: begin bi = 1; gt = 0; end
        1: begin bi = 1; gt = 3; end
        2, 3: begin bi = 1; gt = 5; end
        4: begin bi = 0; gt = 0; end
        5: begin bi = 0; gt = 1; end
        6: begin bi = 0; gt = 2; end
        default: begin bi = 1'($urandom); gt = 4'($urandom); end
      endcase
      drive(1'($urandom), bi, gt, 2'($urandom), 2'($urandom), $urandom_range(0, 3) != 0,
            1'($urandom), acc);
      if (i == 1500) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
